// File: rtl/h264ncontext_pkg.sv
// rtl/h264ncontext_pkg.sv - shared types and constants for the CAVLC N-context store
package h264ncontext_pkg;

    typedef logic [4:0] nc_t;

    // One 4x4-block edge of a macroblock: 4 luma entries plus 2 entries per chroma plane.
    // Used both for the top context (indexed by x) and the left context (indexed by y).
    typedef struct packed {
        nc_t [1:0][1:0] chroma;
        nc_t [3:0]      luma;
    } ctx_word_t;

    localparam logic [1:0] NV_NONE = 2'd0;
    localparam logic [1:0] NV_LEFT = 2'd1;
    localparam logic [1:0] NV_TOP  = 2'd2;
    localparam logic [1:0] NV_AVG  = 2'd3;

    function automatic nc_t nc_avg(input nc_t a, input nc_t b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 6'd1;
        return sum[5:1];
    endfunction

endpackage

// File: rtl/h264ncontext_if.sv
// rtl/h264ncontext_if.sv - buffer/CAVLC to N-context handshake bundle
interface h264ncontext_if;
    import h264ncontext_pkg::*;

    logic       NLOAD;
    logic [2:0] NX;
    logic [2:0] NY;
    logic [1:0] NV;
    logic       NXINC;
    nc_t        NOUT;
    nc_t        NIN;

    modport master (output NLOAD, NX, NY, NV, NXINC, NOUT, input NIN);
    modport slave  (input NLOAD, NX, NY, NV, NXINC, NOUT, output NIN);
endinterface

// File: rtl/h264ncontext_linemem.sv
// rtl/h264ncontext_linemem.sv - 1W1R sync-read line memory holding bottom-row context per MB
module h264ncontext_linemem
    import h264ncontext_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  ctx_word_t     wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output ctx_word_t     rd_data
);

    ctx_word_t mem [DEPTH];

    // Read-before-write: a same-address read returns the previous contents.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/h264ncontext.sv
// rtl/h264ncontext.sv - stores per-block total coeffs and predicts nC from left/top neighbours
module h264ncontext
    import h264ncontext_pkg::*;
#(
    parameter int MAXMBX = 128
) (
    input  logic           CLK,
    input  logic           NEWSLICE,
    input  logic           NEWLINE,
    h264ncontext_if.slave  nbus,
    output logic [6:0]     MBX
);

    localparam int AW = (MAXMBX > 1) ? $clog2(MAXMBX) : 1;

    nc_t       cur  [16];
    nc_t       curc [2][4];
    nc_t       cur_eff  [16];
    nc_t       curc_eff [2][4];
    ctx_word_t left_q;
    ctx_word_t top_q;
    ctx_word_t right_col;
    ctx_word_t bottom_row;
    ctx_word_t rd_data;
    nc_t       nin_q;
    nc_t       na;
    nc_t       nb;
    nc_t       nc;

    logic [AW-1:0] mbx;
    logic [AW:0]   mbx_inc;
    logic          at_end;
    logic          top_pend;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] rd_addr;

    logic       is_chroma;
    logic [1:0] lx;
    logic [1:0] ly;
    logic       cc;
    logic       cx;
    logic       cy;

    assign is_chroma = nbus.NX[2] | nbus.NY[2];
    assign lx        = nbus.NX[1:0];
    assign ly        = nbus.NY[1:0];
    assign cc        = nbus.NX[1];
    assign cx        = nbus.NX[0];
    assign cy        = nbus.NY[0];

    // Storage as it will look after this cycle's NLOAD; feeding this forward
    // gives the same-cycle bypass for both NIN and the NXINC edge capture.
    always_comb begin
        cur_eff  = cur;
        curc_eff = curc;
        if (nbus.NLOAD) begin
            if (is_chroma) begin
                curc_eff[cc][{cy, cx}] = nbus.NOUT;
            end else begin
                cur_eff[{ly, lx}] = nbus.NOUT;
            end
        end
    end

    always_comb begin
        right_col  = '0;
        bottom_row = '0;
        for (int i = 0; i < 4; i++) begin
            right_col.luma[i]  = cur_eff[{2'(i), 2'd3}];
            bottom_row.luma[i] = cur_eff[{2'd3, 2'(i)}];
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                right_col.chroma[c][i]  = curc_eff[c][{1'(i), 1'b1}];
                bottom_row.chroma[c][i] = curc_eff[c][{1'b1, 1'(i)}];
            end
        end
    end

    always_comb begin
        na = '0;
        nb = '0;
        if (is_chroma) begin
            na = cx ? curc_eff[cc][{cy, 1'b0}] : left_q.chroma[cc][cy];
            nb = cy ? curc_eff[cc][{1'b0, cx}] : top_q.chroma[cc][cx];
        end else begin
            na = (lx == 2'd0) ? left_q.luma[ly] : cur_eff[{ly, lx - 2'd1}];
            nb = (ly == 2'd0) ? top_q.luma[lx]  : cur_eff[{ly - 2'd1, lx}];
        end
        case (nbus.NV)
            NV_LEFT: nc = na;
            NV_TOP:  nc = nb;
            NV_AVG:  nc = nc_avg(na, nb);
            default: nc = '0;
        endcase
    end

    // mbx never wraps: past the last MB it holds and the top read falls back to 0.
    always_comb begin
        mbx_inc = {1'b0, mbx} + (AW+1)'(1);
        at_end  = (mbx_inc >= (AW+1)'(MAXMBX));
        rd_en   = (nbus.NXINC | NEWLINE) & ~NEWSLICE;
        wr_en   = nbus.NXINC & ~NEWSLICE;
        rd_addr = '0;
        if (!NEWLINE && !at_end) begin
            rd_addr = mbx_inc[AW-1:0];
        end
    end

    h264ncontext_linemem #(
        .DEPTH (MAXMBX),
        .AW    (AW)
    ) u_linemem (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .wr_addr (mbx),
        .wr_data (bottom_row),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (NEWSLICE) begin
            nin_q    <= '0;
            mbx      <= '0;
            left_q   <= '0;
            top_q    <= '0;
            top_pend <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cur[i] <= '0;
            end
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 4; i++) begin
                    curc[c][i] <= '0;
                end
            end
        end else begin
            nin_q    <= nc;
            cur      <= cur_eff;
            curc     <= curc_eff;
            top_pend <= rd_en;
            if (top_pend) begin
                top_q <= rd_data;
            end
            if (nbus.NXINC) begin
                left_q <= right_col;
            end
            if (NEWLINE) begin
                mbx <= '0;
            end else if (nbus.NXINC && !at_end) begin
                mbx <= mbx_inc[AW-1:0];
            end
        end
    end

    assign nbus.NIN = nin_q;
    assign MBX      = 7'(mbx);

endmodule

// File: tb/tb_h264ncontext.sv
// tb/tb_h264ncontext.sv - directed self-checking bench for h264ncontext
module tb_h264ncontext;

    logic       CLK = 1'b0;
    logic       NEWSLICE;
    logic       NEWLINE;
    logic [6:0] MBX;
    int         tests = 0;
    int         fails = 0;

    h264ncontext_if bus();

    h264ncontext #(.MAXMBX(128)) dut (
        .CLK      (CLK),
        .NEWSLICE (NEWSLICE),
        .NEWLINE  (NEWLINE),
        .nbus     (bus),
        .MBX      (MBX)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_luma(input int x, input int y, input int v);
        bus.NX    = {1'b0, 2'(x)};
        bus.NY    = {1'b0, 2'(y)};
        bus.NOUT  = 5'(v);
        bus.NLOAD = 1'b1;
        step();
        bus.NLOAD = 1'b0;
    endtask

    task automatic load_chroma(input int c, input int x, input int y, input int v);
        bus.NX    = {1'b1, 1'(c), 1'(x)};
        bus.NY    = {1'b1, 1'(c), 1'(y)};
        bus.NOUT  = 5'(v);
        bus.NLOAD = 1'b1;
        step();
        bus.NLOAD = 1'b0;
    endtask

    task automatic query_luma(input int x, input int y, input int nv);
        bus.NX = {1'b0, 2'(x)};
        bus.NY = {1'b0, 2'(y)};
        bus.NV = 2'(nv);
        step();
    endtask

    task automatic query_chroma(input int c, input int x, input int y, input int nv);
        bus.NX = {1'b1, 1'(c), 1'(x)};
        bus.NY = {1'b1, 1'(c), 1'(y)};
        bus.NV = 2'(nv);
        step();
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            bus.NXINC = 1'b1;
            step();
            bus.NXINC = 1'b0;
            step();
            step();
        end
    endtask

    task automatic test_reset();
        bus.NLOAD = 1'b0; bus.NXINC = 1'b0; bus.NOUT = '0;
        bus.NX = '0; bus.NY = '0; bus.NV = 2'd0;
        NEWLINE = 1'b0; NEWSLICE = 1'b1;
        step();
        NEWSLICE = 1'b0;
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL reset_nin: got %0d want 0", bus.NIN); end
        tests++;
        if (MBX !== 7'd0) begin fails++; $display("FAIL reset_mbx: got %0d want 0", MBX); end
        query_luma(0, 0, 0);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL reset_nv0: got %0d want 0", bus.NIN); end
    endtask

    task automatic test_luma_neighbours();
        load_luma(0, 0, 6);
        load_luma(1, 0, 3);
        query_luma(1, 1, 2);
        tests++;
        if (bus.NIN !== 5'd3) begin fails++; $display("FAIL luma_top: got %0d want 3", bus.NIN); end
        query_luma(1, 0, 1);
        tests++;
        if (bus.NIN !== 5'd6) begin fails++; $display("FAIL luma_left: got %0d want 6", bus.NIN); end
        query_luma(0, 0, 2);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL luma_top_edge: got %0d want 0", bus.NIN); end
    endtask

    task automatic test_average();
        load_luma(0, 1, 5);
        load_luma(1, 0, 2);
        query_luma(1, 1, 3);
        tests++;
        if (bus.NIN !== 5'd4) begin fails++; $display("FAIL avg_5_2: got %0d want 4", bus.NIN); end
        load_luma(0, 1, 16);
        load_luma(1, 0, 16);
        query_luma(1, 1, 3);
        tests++;
        if (bus.NIN !== 5'd16) begin fails++; $display("FAIL avg_16_16: got %0d want 16", bus.NIN); end
        load_luma(0, 1, 0);
        load_luma(1, 0, 1);
        query_luma(1, 1, 3);
        tests++;
        if (bus.NIN !== 5'd1) begin fails++; $display("FAIL avg_0_1: got %0d want 1", bus.NIN); end
        query_luma(1, 1, 0);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL avg_nv0: got %0d want 0", bus.NIN); end
    endtask

    task automatic test_chroma();
        load_chroma(0, 0, 0, 8);
        query_chroma(0, 1, 0, 1);
        tests++;
        if (bus.NIN !== 5'd8) begin fails++; $display("FAIL chroma_cb_left: got %0d want 8", bus.NIN); end
        query_chroma(1, 1, 0, 1);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL chroma_cr_left: got %0d want 0", bus.NIN); end
        query_chroma(0, 0, 1, 2);
        tests++;
        if (bus.NIN !== 5'd8) begin fails++; $display("FAIL chroma_cb_top: got %0d want 8", bus.NIN); end
    endtask

    task automatic test_mb_advance();
        for (int y = 0; y < 4; y++) load_luma(3, y, 7);
        bus.NX = 3'b111; bus.NY = 3'b111; bus.NOUT = 5'd9;
        bus.NLOAD = 1'b1; bus.NXINC = 1'b1;
        step();
        bus.NLOAD = 1'b0; bus.NXINC = 1'b0;
        tests++;
        if (MBX !== 7'd1) begin fails++; $display("FAIL advance_mbx: got %0d want 1", MBX); end
        step();
        step();
        for (int y = 0; y < 4; y++) begin
            query_luma(0, y, 1);
            tests++;
            if (bus.NIN !== 5'd7) begin fails++; $display("FAIL advance_left_y%0d: got %0d want 7", y, bus.NIN); end
        end
        query_chroma(1, 0, 1, 1);
        tests++;
        if (bus.NIN !== 5'd9) begin fails++; $display("FAIL advance_cr_bypass: got %0d want 9", bus.NIN); end
        query_chroma(0, 0, 1, 1);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL advance_cb_left: got %0d want 0", bus.NIN); end
    endtask

    task automatic test_line_wrap();
        advance(1);
        for (int x = 0; x < 4; x++) load_luma(x, 3, x + 1);
        advance(1);
        tests++;
        if (MBX !== 7'd3) begin fails++; $display("FAIL wrap_mbx_row0: got %0d want 3", MBX); end
        NEWLINE = 1'b1;
        step();
        NEWLINE = 1'b0;
        tests++;
        if (MBX !== 7'd0) begin fails++; $display("FAIL wrap_newline: got %0d want 0", MBX); end
        step();
        step();
        advance(2);
        tests++;
        if (MBX !== 7'd2) begin fails++; $display("FAIL wrap_mbx_row1: got %0d want 2", MBX); end
        query_luma(2, 0, 2);
        tests++;
        if (bus.NIN !== 5'd3) begin fails++; $display("FAIL wrap_top_x2: got %0d want 3", bus.NIN); end
        query_luma(0, 0, 2);
        tests++;
        if (bus.NIN !== 5'd1) begin fails++; $display("FAIL wrap_top_x0: got %0d want 1", bus.NIN); end
        query_luma(3, 0, 3);
        tests++;
        if (bus.NIN !== 5'd2) begin fails++; $display("FAIL wrap_avg_top: got %0d want 2", bus.NIN); end
        NEWLINE = 1'b1; bus.NXINC = 1'b1;
        step();
        NEWLINE = 1'b0; bus.NXINC = 1'b0;
        tests++;
        if (MBX !== 7'd0) begin fails++; $display("FAIL wrap_newline_nxinc: got %0d want 0", MBX); end
        step();
    endtask

    task automatic test_saturate();
        bus.NXINC = 1'b1;
        repeat (130) step();
        bus.NXINC = 1'b0;
        tests++;
        if (MBX !== 7'd127) begin fails++; $display("FAIL saturate_mbx: got %0d want 127", MBX); end
        step();
    endtask

    task automatic test_newslice();
        bus.NX = 3'b000; bus.NY = 3'b000; bus.NV = 2'd1; bus.NOUT = 5'd11;
        bus.NLOAD = 1'b1; bus.NXINC = 1'b1; NEWLINE = 1'b1; NEWSLICE = 1'b1;
        step();
        bus.NLOAD = 1'b0; bus.NXINC = 1'b0; NEWLINE = 1'b0; NEWSLICE = 1'b0;
        tests++;
        if (MBX !== 7'd0) begin fails++; $display("FAIL slice_mbx: got %0d want 0", MBX); end
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL slice_nin: got %0d want 0", bus.NIN); end
        step();
        step();
        query_luma(1, 0, 1);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL slice_cur_cleared: got %0d want 0", bus.NIN); end
        query_luma(0, 0, 1);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL slice_left_cleared: got %0d want 0", bus.NIN); end
        query_luma(2, 0, 2);
        tests++;
        if (bus.NIN !== 5'd0) begin fails++; $display("FAIL slice_top_cleared: got %0d want 0", bus.NIN); end
    endtask

    initial begin
        test_reset();
        test_luma_neighbours();
        test_average();
        test_chroma();
        test_mb_advance();
        test_line_wrap();
        test_saturate();
        test_newslice();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
